// File: rtl/sp3_uplink_pkg.sv
// Shared widths, capture-state encoding and a saturating counter helper
// for the SP3 uplink frame capture block.
package sp3_uplink_pkg;

    localparam int FRAME_W         = 234;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_FRAME = 8;
    localparam int CNT_W           = 16;
    localparam int IDX_W           = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } cap_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sp3_frame_serializer.sv
// Splits one 234-bit uplink frame into eight 32-bit stream words;
// the last word carries the top 10 bits, zero-extended.
module sp3_frame_serializer
    import sp3_uplink_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [FRAME_W-1:0] i_frame,
    input  logic               i_ready,
    output logic [WORD_W-1:0]  o_data,
    output logic               o_valid,
    output logic               o_last,
    output logic               o_done,
    output logic               o_free
);

    localparam int PAD_W = WORDS_PER_FRAME * WORD_W;

    logic [FRAME_W-1:0] r_frame;
    logic [IDX_W-1:0]   r_idx;
    logic               r_valid;

    logic [PAD_W-1:0]   w_pad;
    logic               w_hs;
    logic               w_last;

    assign w_pad  = {{(PAD_W-FRAME_W){1'b0}}, r_frame};
    assign w_hs   = r_valid & i_ready;
    assign w_last = (r_idx == IDX_W'(WORDS_PER_FRAME-1));

    assign o_data  = r_valid ? w_pad[{r_idx, 5'b0} +: WORD_W] : '0;
    assign o_valid = r_valid;
    assign o_last  = r_valid & w_last;
    assign o_done  = w_hs & w_last;
    // A new frame may load in the same cycle the final word is taken.
    assign o_free  = ~r_valid | o_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_frame <= i_frame;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (w_hs) begin
            if (w_last) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/sp3_uplink_frame_capture.sv
// Armed capture of N uplink frames into a 32-bit valid/ready stream,
// with a serializer plus one holding slot and capture statistics.
module sp3_uplink_frame_capture
    import sp3_uplink_pkg::*;
(
    input  logic               clk20_i,
    input  logic               rst_i,
    input  logic               uplinkrdy_i,
    input  logic               frame_valid_i,
    input  logic [FRAME_W-1:0] uplinkUserData_i,
    input  logic               uplinkFEC_i,
    input  logic               arm_i,
    input  logic [CNT_W-1:0]   nframes_i,
    output logic [WORD_W-1:0]  m_data_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic               m_last_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   frames_captured_o,
    output logic [CNT_W-1:0]   frames_dropped_o,
    output logic [CNT_W-1:0]   fec_count_o
);

    cap_state_t         r_state;
    cap_state_t         w_next;

    logic [CNT_W-1:0]   r_nframes;
    logic [CNT_W-1:0]   r_captured;
    logic [CNT_W-1:0]   r_dropped;
    logic [CNT_W-1:0]   r_fec;
    logic [FRAME_W-1:0] r_hold;
    logic               r_hold_v;

    logic               w_ser_free;
    logic               w_ser_done;
    logic               w_ser_valid;
    logic               w_ser_load;
    logic [FRAME_W-1:0] w_ser_frame;
    logic               w_arrive;
    logic               w_accept;
    logic               w_drop;
    logic               w_to_hold;
    logic               w_arm;
    logic [CNT_W-1:0]   w_cap_next;

    assign w_arm      = arm_i & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_arrive   = (r_state == ST_CAPTURE) & frame_valid_i & uplinkrdy_i
                        & (r_captured != r_nframes);
    assign w_accept   = w_arrive & (w_ser_free | ~r_hold_v);
    assign w_drop     = w_arrive & ~w_accept;
    // A full holding slot always drains into the serializer first.
    assign w_to_hold  = w_accept & (r_hold_v | ~w_ser_free);
    assign w_ser_load = w_ser_free & (r_hold_v | w_accept);
    assign w_ser_frame = r_hold_v ? r_hold : uplinkUserData_i;
    assign w_cap_next = sat_inc(r_captured);

    sp3_frame_serializer u_ser (
        .i_clk   (clk20_i),
        .i_rst   (rst_i),
        .i_load  (w_ser_load),
        .i_frame (w_ser_frame),
        .i_ready (m_ready_i),
        .o_data  (m_data_o),
        .o_valid (w_ser_valid),
        .o_last  (m_last_o),
        .o_done  (w_ser_done),
        .o_free  (w_ser_free)
    );

    assign m_valid_o = w_ser_valid;

    always_ff @(posedge clk20_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (arm_i) w_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (r_nframes == '0) w_next = ST_DONE;
                else if (uplinkrdy_i) w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if ((r_captured == r_nframes) ||
                    (w_accept && (w_cap_next == r_nframes)))
                    w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!r_hold_v && (!w_ser_valid || w_ser_done))
                    w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk20_i) begin
        if (rst_i) begin
            r_nframes  <= '0;
            r_captured <= '0;
            r_dropped  <= '0;
            r_fec      <= '0;
        end else if (w_arm) begin
            r_nframes  <= nframes_i;
            r_captured <= '0;
            r_dropped  <= '0;
            r_fec      <= '0;
        end else begin
            if (w_accept) r_captured <= w_cap_next;
            if (w_accept && uplinkFEC_i) r_fec <= sat_inc(r_fec);
            if (w_drop) r_dropped <= sat_inc(r_dropped);
        end
    end

    always_ff @(posedge clk20_i) begin
        if (rst_i) begin
            r_hold   <= '0;
            r_hold_v <= 1'b0;
        end else if (w_to_hold) begin
            r_hold   <= uplinkUserData_i;
            r_hold_v <= 1'b1;
        end else if (w_ser_load && r_hold_v) begin
            r_hold_v <= 1'b0;
        end
    end

    assign busy_o = (r_state == ST_ARMED) | (r_state == ST_CAPTURE)
                    | (r_state == ST_DRAIN);
    assign done_o = (r_state == ST_DONE);
    assign frames_captured_o = r_captured;
    assign frames_dropped_o  = r_dropped;
    assign fec_count_o       = r_fec;

endmodule
